// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_program_loader
// Brief    : Receives a framed, XOR-checksummed byte stream, writes instruction
//            words into instruction memory and holds the core in reset until
//            a verified load completes.
// Revision : 1.0 - initial release
// ============================================================================
module imem_program_loader #(
  parameter int         DATA_WIDTH    = 20,
  parameter int         ADDRESS_WIDTH = 8,
  parameter int         MEM_SIZE      = 256,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    imem_wdata,
  output logic                     cpu_hold,
  output logic                     load_done,
  output logic                     load_error,
  output logic [ADDRESS_WIDTH:0]   words_loaded
);

  // Word counters must hold 256 even for narrow address widths.
  localparam int         c_CW      = (ADDRESS_WIDTH + 1 > 9) ? ADDRESS_WIDTH + 1 : 9;
  localparam logic [7:0] c_HI_MASK = 8'(16'h00FF << (DATA_WIDTH - 16));

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_COUNT = 4'd1,
    S_B0    = 4'd2,
    S_B1    = 4'd3,
    S_B2    = 4'd4,
    S_WRITE = 4'd5,
    S_CHECK = 4'd6,
    S_DONE  = 4'd7,
    S_ERROR = 4'd8
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_CW-1:0]       r_n;
  logic [c_CW-1:0]       r_count;
  logic [7:0]            r_chk;
  logic [7:0]            r_b0;
  logic [7:0]            r_b1;
  logic                  w_accept;
  logic                  w_sync;
  logic                  w_hi_bad;
  logic                  w_last;
  logic [c_CW-1:0]       w_n;
  logic [DATA_WIDTH-1:0] w_word;

  assign rx_ready     = (r_state != S_WRITE);
  assign imem_we      = (r_state == S_WRITE);
  assign words_loaded = r_count[ADDRESS_WIDTH:0];

  assign w_accept = rx_valid && rx_ready;
  assign w_sync   = (rx_data == SYNC_BYTE);
  assign w_hi_bad = ((rx_data & c_HI_MASK) != 8'h00);
  assign w_last   = ((r_count + c_CW'(1)) == r_n);
  assign w_n      = (rx_data == 8'h00) ? c_CW'(256) : c_CW'(rx_data);
  assign w_word   = DATA_WIDTH'({rx_data, r_b1, r_b0});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_sync) w_state_nxt = S_COUNT;
      S_COUNT: if (w_accept) w_state_nxt = (w_n > c_CW'(MEM_SIZE)) ? S_ERROR : S_B0;
      S_B0:    if (w_accept) w_state_nxt = S_B1;
      S_B1:    if (w_accept) w_state_nxt = S_B2;
      S_B2:    if (w_accept) w_state_nxt = w_hi_bad ? S_ERROR : S_WRITE;
      S_WRITE: w_state_nxt = w_last ? S_CHECK : S_B0;
      S_CHECK: if (w_accept) w_state_nxt = (rx_data == r_chk) ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR: if (w_accept && w_sync) w_state_nxt = S_COUNT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_count    <= '0;
      r_chk      <= 8'h00;
      r_b0       <= 8'h00;
      r_b1       <= 8'h00;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      cpu_hold   <= (w_state_nxt != S_DONE);
      load_done  <= (w_state_nxt == S_DONE);
      load_error <= (w_state_nxt == S_ERROR);
      case (r_state)
        S_COUNT: if (w_accept) begin
          r_n     <= w_n;
          r_count <= '0;
          r_chk   <= 8'h00;
        end
        S_B0: if (w_accept) begin
          r_b0  <= rx_data;
          r_chk <= r_chk ^ rx_data;
        end
        S_B1: if (w_accept) begin
          r_b1  <= rx_data;
          r_chk <= r_chk ^ rx_data;
        end
        // Address and data load together so both are stable for the whole WRITE cycle.
        S_B2: if (w_accept && !w_hi_bad) begin
          imem_wdata <= w_word;
          imem_addr  <= r_count[ADDRESS_WIDTH-1:0];
          r_chk      <= r_chk ^ rx_data;
        end
        S_WRITE: r_count <= r_count + c_CW'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_program_loader
// Brief    : Directed self-checking bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_program_loader;
  localparam int DW = 20;
  localparam int AW = 8;
  localparam int MS = 256;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  imem_program_loader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  wr_t           exp_q[$];
  logic [DW-1:0] wr_log[$];
  bit            stall_seen = 1'b0;
  int            last_addr = -1;
  int            n_writes = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Frame-level reference: locate sync, read N, slice 3-byte words, XOR-verify.
  function automatic void model(input bq_t s, output bit complete, output bit ok, output int n);
    int         i;
    logic [7:0] c;
    logic [7:0] b0, b1, b2;
    wr_t        w;
    i = 0; c = 8'h00; complete = 1'b0; ok = 1'b0; n = 0;
    while (i < s.size() && s[i] != 8'hA5) i++;
    if (i + 1 >= s.size()) return;
    n = (s[i+1] == 8'h00) ? 256 : int'(s[i+1]);
    i += 2;
    if (n > MS) begin complete = 1'b1; return; end
    for (int k = 0; k < n; k++) begin
      if (i + 2 >= s.size()) return;
      b0 = s[i]; b1 = s[i+1]; b2 = s[i+2];
      if ((b2 >> (DW - 16)) != 8'h00) begin complete = 1'b1; return; end
      w.a = AW'(k);
      w.d = DW'({b2, b1, b0});
      exp_q.push_back(w);
      c = c ^ b0 ^ b1 ^ b2;
      i += 3;
    end
    if (i >= s.size()) return;
    complete = 1'b1;
    ok = (s[i] == c);
  endfunction

  // Called at a negedge; returns at a negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    bit acc;
    t = 0; acc = 1'b0;
    if (gap) begin rx_valid = 1'b0; @(negedge clk); end
    rx_data = b; rx_valid = 1'b1;
    while (!acc && t < 20) begin
      if (rx_ready) acc = 1'b1;
      else stall_seen = 1'b1;
      @(negedge clk);
      t++;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL byte_accept actual=timeout required=accepted byte=%0h", b);
    end
  endtask

  task automatic run_frame(input string nm, input bq_t s, input bit gaps);
    bit comp, ok;
    int n;
    model(s, comp, ok, n);
    wr_log.delete();
    foreach (s[i]) send_byte(s[i], gaps && (i % 2 == 1));
    repeat (3) @(negedge clk);
    check({nm, "_complete"}, 32'(comp), 32'd1);
    check({nm, "_done"}, load_done, ok);
    check({nm, "_error"}, load_error, !ok);
    check({nm, "_hold"}, cpu_hold, !ok);
    check({nm, "_pending_writes"}, exp_q.size(), 0);
    if (ok) check({nm, "_words"}, words_loaded, n);
  endtask

  // Every-cycle compare against the model's write list and output invariants.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      check("we_only_when_stalled", imem_we, !rx_ready);
      check("hold_vs_done", cpu_hold, !load_done);
      check("done_and_error", load_done & load_error, 1'b0);
      if (imem_we) begin
        n_writes++;
        last_addr = int'(imem_addr);
        wr_log.push_back(imem_wdata);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%0h@%0h required=no_write", imem_wdata, imem_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", imem_addr, e.a);
          check("wr_data", imem_wdata, e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f2, f3, f4, f5, f6;
    logic [7:0] c5;
    int nw;
    bit comp, ok;
    int n;

    // T1: reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hold", cpu_hold, 1'b1);
    check("rst_ready", rx_ready, 1'b1);
    check("rst_we", imem_we, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_error", load_error, 1'b0);
    check("rst_words", words_loaded, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // T2: good load
    f2 = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A, 8'h07};
    run_frame("t2", f2, 1'b1);
    check("t2_first_word", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hDEAD, 32'h51234);
    check("t2_last_wdata", imem_wdata, 20'hA5678);
    check("t2_last_addr", last_addr, 1);
    check("t2_words_lit", words_loaded, 2);
    check("t2_done_lit", load_done, 1'b1);

    // T3: bad checksum, then reload
    f3 = f2;
    f3[8] = 8'h08;
    nw = n_writes;
    run_frame("t3", f3, 1'b0);
    check("t3_writes", n_writes - nw, 2);
    check("t3_error_lit", load_error, 1'b1);
    run_frame("t3_reload", f2, 1'b1);
    check("t3_reload_done_lit", load_done, 1'b1);

    // T4: high-bit range fault after discarded bytes
    f4 = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h15};
    nw = n_writes;
    run_frame("t4", f4, 1'b1);
    check("t4_no_write", n_writes - nw, 0);
    check("t4_error_lit", load_error, 1'b1);

    // T5: full depth, N=0 means 256
    f5 = '{8'hA5, 8'h00};
    c5 = 8'h00;
    for (int w = 0; w < 256; w++) begin
      f5.push_back(8'(w));
      f5.push_back(~8'(w));
      f5.push_back(8'(w) & 8'h0F);
      c5 = c5 ^ 8'(w) ^ ~8'(w) ^ (8'(w) & 8'h0F);
    end
    f5.push_back(c5);
    nw = n_writes;
    run_frame("t5", f5, 1'b0);
    check("t5_writes", n_writes - nw, 256);
    check("t5_words_lit", words_loaded, 256);
    check("t5_last_addr", last_addr, 255);
    check("t5_done_lit", load_done, 1'b1);

    // T6: stall through WRITE, then reset after one word
    f6 = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h03, 8'h44};
    model(f6, comp, ok, n);
    check("t6_model_partial", 32'(comp), 32'd0);
    stall_seen = 1'b0;
    nw = n_writes;
    foreach (f6[i]) send_byte(f6[i], 1'b0);
    check("t6_stall_seen", 32'(stall_seen), 32'd1);
    check("t6_one_write", n_writes - nw, 1);
    check("t6_wdata_lit", imem_wdata, 20'h32211);
    check("t6_words", words_loaded, 1);
    check("t6_hold_loading", cpu_hold, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_hold", cpu_hold, 1'b1);
    check("t6_rst_error", load_error, 1'b0);
    check("t6_rst_done", load_done, 1'b0);
    check("t6_rst_ready", rx_ready, 1'b1);
    check("t6_rst_words", words_loaded, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_pending_writes", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
